// File: rtl/rf_reader.sv
// rf_reader: sequential read-back engine for the register file.
//
// On an accepted start it walks every register two at a time through the
// two combinational read ports. Each fetched pair is snapshotted into buf0
// and buf1 and then streamed as two valid/ready beats. A wrapping sum of
// all accepted beats is kept for the current or most recent sweep.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begin a sweep (sampled only in IDLE)
//   rn1, rn2   read addresses to the register file (held outside FETCH)
//   rd1, rd2   read data from the register file (combinational from rn1/rn2)
//   out_valid  beat available on out_data/out_idx
//   out_ready  sink accepts the beat
//   out_data   register value of the current beat
//   out_idx    register number of the current beat
//   busy       sweep in progress (FETCH/SEND0/SEND1)
//   done       one-cycle pulse after the last beat is accepted
//   sum        wrapping sum of accepted beats
module rf_reader #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] rn1,
    output logic [AW-1:0] rn2,
    input  logic [DW-1:0] rd1,
    input  logic [DW-1:0] rd2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_idx,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] sum
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND0,
        SEND1,
        DONE
    } state_t;

    // Base address of the final register pair in the sweep.
    localparam logic [AW-1:0] LAST = AW'(NREG - 2);

    state_t        state;
    logic [AW-1:0] base;
    logic [DW-1:0] buf0;
    logic [DW-1:0] buf1;

    // All outputs are registered here. The read addresses are loaded on
    // the transition into FETCH, so they are valid for the whole FETCH
    // cycle and simply hold their value afterwards.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register update in this
        // block reading pre-edge values, so ordering inside the block is free.
        if (reset) begin
            state     <= IDLE;
            base      <= '0;
            buf0      <= '0;
            buf1      <= '0;
            rn1       <= '0;
            rn2       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base  <= '0;
                        sum   <= '0;
                        rn1   <= '0;
                        rn2   <= AW'(1);
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // Snapshot both registers; later rf writes do not
                    // affect the beats of this pair.
                    buf0      <= rd1;
                    buf1      <= rd2;
                    out_valid <= 1'b1;
                    out_data  <= rd1;
                    out_idx   <= base;
                    state     <= SEND0;
                end
                SEND0: begin
                    if (out_ready) begin
                        sum      <= sum + buf0;
                        out_data <= buf1;
                        out_idx  <= base + AW'(1);
                        state    <= SEND1;
                    end
                end
                SEND1: begin
                    if (out_ready) begin
                        sum       <= sum + buf1;
                        out_valid <= 1'b0;
                        if (base == LAST) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            base  <= base + AW'(2);
                            rn1   <= base + AW'(2);
                            rn2   <= base + AW'(3);
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rf_reader.md
# rf_reader

Sequential read-back engine for the 32x32 register file (`rf`). On `start` it sweeps every register through the two read ports, two registers per fetch, and streams each value out with a valid/ready handshake. It also accumulates a wrapping 32-bit sum of all streamed values. It is the read-side counterpart of the write-loop that fills the register file, used for dumping state and for self-check in labs and system benches.

## Interface
Parameters:
- `NREG`, 32, number of registers swept; must be even and ≤ 2^`AW`
- `AW`, 5, register-number width
- `DW`, 32, data width

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a sweep; sampled only in IDLE
- `rn1`  out  AW  read address, port 1 (to `rf`)
- `rn2`  out  AW  read address, port 2 (to `rf`)
- `rd1`  in  DW  read data, port 1; combinational from `rn1`
- `rd2`  in  DW  read data, port 2; combinational from `rn2`
- `out_valid`  out  1  `out_data`/`out_idx` hold a beat
- `out_ready`  in  1  sink accepts the beat
- `out_data`  out  DW  register value
- `out_idx`  out  AW  register number of `out_data`
- `busy`  out  1  high from the cycle after an accepted start until DONE
- `done`  out  1  one-cycle pulse after the last beat is accepted
- `sum`  out  DW  wrapping sum of accepted beats for the current or last sweep

## Operation
- The block never drives the `rf` write port. Writes by others during a sweep are legal.
- States: IDLE, FETCH, SEND0, SEND1, DONE. Internal `base` register (AW bits), buffers `buf0` and `buf1` (DW each).
- IDLE, with `start=1`: `base←0`, `sum←0`, go to FETCH. `start` is ignored in every other state.
- FETCH:
  - Drive `rn1=base` and `rn2=base+1`.
  - At the clock edge, latch `buf0←rd1` and `buf1←rd2`, then go to SEND0.
- SEND0:
  - `out_valid=1`, `out_data=buf0`, `out_idx=base`.
  - On `out_ready`: `sum←sum+buf0` (mod 2^DW), go to SEND1.
- SEND1:
  - `out_valid=1`, `out_data=buf1`, `out_idx=base+1`.
  - On `out_ready`: `sum←sum+buf1`.
  - If `base==NREG-2`, go to DONE; else `base←base+2` and go to FETCH.
- DONE: `done=1` for exactly one cycle, then go to IDLE. `sum` holds its value until the next accepted start.
- Beats are emitted in strictly ascending `out_idx` order, 0..NREG-1, with no gaps or repeats.
- `rn1` and `rn2` hold their last values outside FETCH.

## Timing
- Reset, effective at the next edge: state=IDLE and all outputs 0 (`rn1`, `rn2`, `out_valid`, `out_data`, `out_idx`, `busy`, `done`, `sum`); `base` and the buffers are cleared.
- Reset mid-sweep aborts immediately. No further beats are emitted and `done` is not pulsed.
- Start accepted at edge n:
  - FETCH in cycle n+1.
  - First `out_valid` in cycle n+2.
- Each register pair takes at least 3 cycles (FETCH, SEND0, SEND1).
- With `out_ready` held at 1, a full sweep is 48 cycles from FETCH to the last handshake, and `done` is high in the following cycle.
- Handshake:
  - A beat transfers on any edge where `out_valid && out_ready`.
  - While `out_ready=0`, `out_valid`, `out_data` and `out_idx` hold stable.
  - `out_valid` is never withdrawn before the transfer.
- Values are snapshotted in FETCH. An `rf` write to a register after its fetch does not change the streamed value.
- `out_valid` and `done` are never high in the same cycle.

## Test plan
- Preload `rf` with reg[i]=i*i, start, `out_ready`=1 -> 32 beats, idx 0..31, data 0,1,4,…,961; `sum`=10416; `done` is a single pulse; `busy` drops at the same time `done` rises.
- Same preload, `out_ready` low for 5 cycles while idx=7 is presented -> `out_data`=49 and `out_idx`=7 stay stable, exactly one idx-7 beat is transferred, and the sweep then continues with idx 8 (data 64).
- Pulse `start` again at idx 10 mid-sweep -> no restart; the sequence continues 11, 12, …; final `sum`=10416.
- Assert `reset` while idx 12 is valid -> next cycle all outputs are 0 and no `done` is pulsed; a new `start` restarts at idx 0 with `sum` cleared.
- After reg 4 is fetched (SEND0 for idx 4), write reg4=0xDEADBEEF -> the streamed beat at idx 4 is 16; a second sweep shows 0xDEADBEEF at idx 4.
- Preload all registers with 0xFFFFFFFF -> `sum` wraps to 0xFFFFFFE0 after 32 beats.
